// File: rtl/spiking_pkg.sv
// Shared types and helpers for the spiking systolic-array processing elements.
package spiking_pkg;

    typedef enum logic [0:0] {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_t;

    localparam int RESET_ZERO = 0;
    localparam int RESET_SUB  = 1;

    // Clamp a wide signed value into the signed range of a `width`-bit accumulator.
    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] x, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/spiking_sat_add.sv
// Signed saturating add/subtract: y = sat(a + b) or sat(a - b), clamped to WIDTH bits.
module spiking_sat_add
    import spiking_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] y
);

    logic signed [63:0] wide;

    always_comb begin
        wide = sub ? (64'(a) - 64'(b)) : (64'(a) + 64'(b));
        y    = WIDTH'(sat_acc(wide, WIDTH));
    end

endmodule

// File: rtl/lif_spiking_pe.sv
// Leaky integrate-and-fire PE: integrates weighted row spikes, fires on timestep
// boundaries, and forwards row/column/step markers to its neighbours.
module lif_spiking_pe
    import spiking_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int LEAK_SHIFT   = 4,
    parameter int REFRAC_STEPS = 2,
    parameter int RESET_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_clear,
    input  logic                         in_step,
    input  logic signed [ACC_WIDTH-1:0]  threshold,
    input  logic                         in_row,
    input  logic signed [DATA_WIDTH-1:0] in_col,
    output logic                         out_row,
    output logic signed [DATA_WIDTH-1:0] out_col,
    output logic                         out_step,
    output logic                         out_spike,
    output logic signed [ACC_WIDTH-1:0]  out_potential,
    output logic                         out_refrac
);

    localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    state_t                        state_q, state_d;
    logic [RC_W-1:0]               rc_q, rc_d;
    logic signed [ACC_WIDTH-1:0]   v_q, v_d;
    logic                          spike_q, spike_d;
    logic                          row_q, row_d;
    logic signed [DATA_WIDTH-1:0]  col_q, col_d;
    logic                          step_q, step_d;

    logic signed [ACC_WIDTH-1:0]   col_ext;
    logic signed [ACC_WIDTH-1:0]   add_b;
    logic signed [ACC_WIDTH-1:0]   v_acc;
    logic signed [ACC_WIDTH-1:0]   v_leak;
    logic signed [ACC_WIDTH-1:0]   v_sub;

    assign col_ext = {{(ACC_WIDTH - DATA_WIDTH){in_col[DATA_WIDTH-1]}}, in_col};
    assign add_b   = in_row ? col_ext : '0;

    spiking_sat_add #(.WIDTH(ACC_WIDTH)) u_integrate (
        .a   (v_q),
        .b   (add_b),
        .sub (1'b0),
        .y   (v_acc)
    );

    // Leak only shrinks magnitude, so this difference cannot overflow.
    generate
        if (LEAK_SHIFT == 0) begin : g_no_leak
            assign v_leak = v_acc;
        end else begin : g_leak
            assign v_leak = v_acc - (v_acc >>> LEAK_SHIFT);
        end
    endgenerate

    spiking_sat_add #(.WIDTH(ACC_WIDTH)) u_subtract (
        .a   (v_leak),
        .b   (threshold),
        .sub (1'b1),
        .y   (v_sub)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        row_d   = in_row;
        col_d   = in_col;
        step_d  = in_step;
        state_d = state_q;
        rc_d    = rc_q;
        v_d     = v_q;
        spike_d = 1'b0;

        if (in_clear) begin
            state_d = INTEG;
            rc_d    = '0;
            v_d     = '0;
        end else begin
            case (state_q)
                INTEG: begin
                    if (in_step) begin
                        if (v_leak >= threshold) begin
                            spike_d = 1'b1;
                            v_d     = (RESET_MODE == RESET_SUB) ? v_sub : '0;
                            if (REFRAC_STEPS > 0) begin
                                state_d = REFRAC;
                                rc_d    = RC_W'(REFRAC_STEPS);
                            end
                        end else begin
                            v_d = v_leak;
                        end
                    end else if (in_row) begin
                        v_d = v_acc;
                    end
                end
                REFRAC: begin
                    if (in_step) begin
                        rc_d = rc_q - RC_W'(1);
                        if (rc_q == RC_W'(1)) begin
                            state_d = INTEG;
                        end
                    end
                end
                default: state_d = INTEG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) begin
            row_q  <= 1'b0;
            col_q  <= '0;
            step_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            step_q <= step_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= INTEG;
            rc_q    <= '0;
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign out_row       = row_q;
    assign out_col       = col_q;
    assign out_step      = step_q;
    assign out_spike     = spike_q;
    assign out_potential = v_q;
    assign out_refrac    = (state_q == REFRAC);

endmodule

// File: tb/tb_lif_spiking_pe.sv
// Directed bench for lif_spiking_pe: four instances with different parameter sets share one stimulus bus.
module tb_lif_spiking_pe;

    logic clk;
    logic rstn;
    logic in_clear;
    logic in_step;
    logic in_row;
    logic signed [15:0] in_col;
    logic signed [23:0] thr;
    logic signed [16:0] thr17;

    logic m0_row, m0_step, m0_spike, m0_refrac;
    logic signed [15:0] m0_col;
    logic signed [23:0] m0_pot;
    logic lk_row, lk_step, lk_spike, lk_refrac;
    logic signed [15:0] lk_col;
    logic signed [23:0] lk_pot;
    logic sb_row, sb_step, sb_spike, sb_refrac;
    logic signed [15:0] sb_col;
    logic signed [23:0] sb_pot;
    logic st_row, st_step, st_spike, st_refrac;
    logic signed [15:0] st_col;
    logic signed [16:0] st_pot;

    int n_checks = 0;
    int n_fail   = 0;

    lif_spiking_pe #(.DATA_WIDTH(16), .ACC_WIDTH(24), .LEAK_SHIFT(0), .REFRAC_STEPS(2), .RESET_MODE(0)) u_m0 (
        .clk(clk), .rstn(rstn), .in_clear(in_clear), .in_step(in_step), .threshold(thr),
        .in_row(in_row), .in_col(in_col), .out_row(m0_row), .out_col(m0_col), .out_step(m0_step),
        .out_spike(m0_spike), .out_potential(m0_pot), .out_refrac(m0_refrac));

    lif_spiking_pe #(.DATA_WIDTH(16), .ACC_WIDTH(24), .LEAK_SHIFT(4), .REFRAC_STEPS(2), .RESET_MODE(0)) u_leak (
        .clk(clk), .rstn(rstn), .in_clear(in_clear), .in_step(in_step), .threshold(thr),
        .in_row(in_row), .in_col(in_col), .out_row(lk_row), .out_col(lk_col), .out_step(lk_step),
        .out_spike(lk_spike), .out_potential(lk_pot), .out_refrac(lk_refrac));

    lif_spiking_pe #(.DATA_WIDTH(16), .ACC_WIDTH(24), .LEAK_SHIFT(0), .REFRAC_STEPS(2), .RESET_MODE(1)) u_sub (
        .clk(clk), .rstn(rstn), .in_clear(in_clear), .in_step(in_step), .threshold(thr),
        .in_row(in_row), .in_col(in_col), .out_row(sb_row), .out_col(sb_col), .out_step(sb_step),
        .out_spike(sb_spike), .out_potential(sb_pot), .out_refrac(sb_refrac));

    lif_spiking_pe #(.DATA_WIDTH(16), .ACC_WIDTH(17), .LEAK_SHIFT(0), .REFRAC_STEPS(2), .RESET_MODE(0)) u_sat (
        .clk(clk), .rstn(rstn), .in_clear(in_clear), .in_step(in_step), .threshold(thr17),
        .in_row(in_row), .in_col(in_col), .out_row(st_row), .out_col(st_col), .out_step(st_step),
        .out_spike(st_spike), .out_potential(st_pot), .out_refrac(st_refrac));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_clear = 1'b0;
        in_step  = 1'b0;
        in_row   = 1'b0;
        in_col   = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        in_clear = 1'b1;
        cyc();
        in_clear = 1'b0;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        idle_inputs();
        thr    = 24'sd1000;
        thr17  = 17'sd1000;
        in_row = 1'b1;
        in_col = 16'sd5;
        cyc();
        cyc();
        n_checks++; if (m0_row !== 1'b0)  begin n_fail++; $display("FAIL reset_row: got %0b want 0", m0_row); end
        n_checks++; if (m0_col !== 16'sd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", m0_col); end
        n_checks++; if (m0_step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %0b want 0", m0_step); end
        n_checks++; if (m0_spike !== 1'b0) begin n_fail++; $display("FAIL reset_spike: got %0b want 0", m0_spike); end
        n_checks++; if (m0_pot !== 24'sd0) begin n_fail++; $display("FAIL reset_pot: got %0d want 0", m0_pot); end
        n_checks++; if (m0_refrac !== 1'b0) begin n_fail++; $display("FAIL reset_refrac: got %0b want 0", m0_refrac); end
        rstn = 1'b1;
        cyc();
        n_checks++; if (m0_row !== 1'b1)   begin n_fail++; $display("FAIL fwd_row: got %0b want 1", m0_row); end
        n_checks++; if (m0_col !== 16'sd5) begin n_fail++; $display("FAIL fwd_col: got %0d want 5", m0_col); end
    endtask

    task automatic test_integrate_fire();
        do_clear();
        thr    = 24'sd100;
        in_row = 1'b1;
        in_col = 16'sd30;
        repeat (4) cyc();
        n_checks++; if (m0_pot !== 24'sd120) begin n_fail++; $display("FAIL integ_pot: got %0d want 120", m0_pot); end
        n_checks++; if (m0_spike !== 1'b0)   begin n_fail++; $display("FAIL integ_nospike: got %0b want 0", m0_spike); end
        in_row  = 1'b0;
        in_col  = '0;
        in_step = 1'b1;
        cyc();
        n_checks++; if (m0_spike !== 1'b1)  begin n_fail++; $display("FAIL fire_spike: got %0b want 1", m0_spike); end
        n_checks++; if (m0_pot !== 24'sd0)  begin n_fail++; $display("FAIL fire_pot: got %0d want 0", m0_pot); end
        n_checks++; if (m0_refrac !== 1'b1) begin n_fail++; $display("FAIL fire_refrac: got %0b want 1", m0_refrac); end
        n_checks++; if (m0_step !== 1'b1)   begin n_fail++; $display("FAIL fire_step_fwd: got %0b want 1", m0_step); end
        in_step = 1'b0;
        cyc();
        n_checks++; if (m0_spike !== 1'b0)  begin n_fail++; $display("FAIL fire_pulse_end: got %0b want 0", m0_spike); end
    endtask

    task automatic test_leak();
        do_clear();
        thr    = 24'sd1000;
        in_row = 1'b1;
        in_col = 16'sd64;
        cyc();
        n_checks++; if (lk_pot !== 24'sd64) begin n_fail++; $display("FAIL leak_load: got %0d want 64", lk_pot); end
        in_row  = 1'b0;
        in_col  = '0;
        in_step = 1'b1;
        cyc();
        n_checks++; if (lk_pot !== 24'sd60) begin n_fail++; $display("FAIL leak_step1: got %0d want 60", lk_pot); end
        n_checks++; if (lk_spike !== 1'b0)  begin n_fail++; $display("FAIL leak_nospike: got %0b want 0", lk_spike); end
        cyc();
        n_checks++; if (lk_pot !== 24'sd57) begin n_fail++; $display("FAIL leak_step2: got %0d want 57", lk_pot); end
        in_step = 1'b0;
    endtask

    task automatic test_subtract_refrac();
        do_clear();
        thr    = 24'sd100;
        in_row = 1'b1;
        in_col = 16'sd130;
        cyc();
        n_checks++; if (sb_pot !== 24'sd130) begin n_fail++; $display("FAIL sub_load: got %0d want 130", sb_pot); end
        in_row  = 1'b0;
        in_col  = '0;
        in_step = 1'b1;
        cyc();
        n_checks++; if (sb_spike !== 1'b1)  begin n_fail++; $display("FAIL sub_spike: got %0b want 1", sb_spike); end
        n_checks++; if (sb_pot !== 24'sd30) begin n_fail++; $display("FAIL sub_pot: got %0d want 30", sb_pot); end
        in_step = 1'b0;
        in_row  = 1'b1;
        in_col  = 16'sd50;
        cyc();
        n_checks++; if (sb_pot !== 24'sd30) begin n_fail++; $display("FAIL refrac_hold: got %0d want 30", sb_pot); end
        in_step = 1'b1;
        cyc();
        n_checks++; if (sb_refrac !== 1'b1) begin n_fail++; $display("FAIL refrac_step1: got %0b want 1", sb_refrac); end
        cyc();
        n_checks++; if (sb_refrac !== 1'b0) begin n_fail++; $display("FAIL refrac_exit: got %0b want 0", sb_refrac); end
        n_checks++; if (sb_spike !== 1'b0)  begin n_fail++; $display("FAIL refrac_nofire: got %0b want 0", sb_spike); end
        in_step = 1'b0;
        cyc();
        n_checks++; if (sb_pot !== 24'sd80) begin n_fail++; $display("FAIL post_refrac_integ: got %0d want 80", sb_pot); end
    endtask

    task automatic test_saturation();
        logic signed [16:0] exp_hi;
        logic signed [16:0] exp_lo;
        exp_hi = 17'(65535);
        exp_lo = 17'(-65536);
        thr17  = 17'sd1000;
        do_clear();
        in_row = 1'b1;
        in_col = 16'sd32767;
        repeat (3) cyc();
        n_checks++; if (st_pot !== exp_hi) begin n_fail++; $display("FAIL sat_pos: got %0d want %0d", st_pot, exp_hi); end
        cyc();
        n_checks++; if (st_pot !== exp_hi) begin n_fail++; $display("FAIL sat_pos_hold: got %0d want %0d", st_pot, exp_hi); end
        do_clear();
        in_row = 1'b1;
        in_col = -16'sd32768;
        repeat (3) cyc();
        n_checks++; if (st_pot !== exp_lo) begin n_fail++; $display("FAIL sat_neg: got %0d want %0d", st_pot, exp_lo); end
        idle_inputs();
    endtask

    task automatic test_clear_priority();
        do_clear();
        thr    = 24'sd100;
        in_row = 1'b1;
        in_col = 16'sd30;
        repeat (4) cyc();
        in_row   = 1'b0;
        in_col   = '0;
        in_step  = 1'b1;
        in_clear = 1'b1;
        cyc();
        n_checks++; if (m0_spike !== 1'b0)  begin n_fail++; $display("FAIL clr_spike: got %0b want 0", m0_spike); end
        n_checks++; if (m0_pot !== 24'sd0)  begin n_fail++; $display("FAIL clr_pot: got %0d want 0", m0_pot); end
        n_checks++; if (m0_refrac !== 1'b0) begin n_fail++; $display("FAIL clr_refrac: got %0b want 0", m0_refrac); end
        n_checks++; if (m0_step !== 1'b1)   begin n_fail++; $display("FAIL clr_step_fwd: got %0b want 1", m0_step); end
        idle_inputs();
        cyc();
        n_checks++; if (m0_spike !== 1'b0)  begin n_fail++; $display("FAIL clr_after: got %0b want 0", m0_spike); end
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_leak();
        test_subtract_refrac();
        test_saturation();
        test_clear_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_spiking_pe.md
# lif_spiking_pe

Parametrised leaky integrate-and-fire processing element for the spiking systolic array, successor to the basic integrating spiking PE. Each cycle it accumulates the signed column operand into a saturating membrane potential when the row spike is present, and forwards row, column and timestep markers to its neighbours with one-cycle latency. At each timestep boundary it applies leak, compares against a programmable threshold, emits a one-cycle output spike, applies the configured reset mode, and enters a refractory period.

## Interface
- `DATA_WIDTH`, 16, width of signed column operand
- `ACC_WIDTH`, 24, width of signed membrane potential; must be ≥ `DATA_WIDTH`+1
- `LEAK_SHIFT`, 4, leak = potential >>> `LEAK_SHIFT` per timestep; 0 disables leak
- `REFRAC_STEPS`, 2, timesteps held in refractory after a spike; 0 disables refractory
- `RESET_MODE`, 0, 0 = reset-to-zero on spike, 1 = subtract threshold on spike

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: sole clock, rising edge
- `rstn` in 1: synchronous active-low reset
- `in_clear` in 1: soft clear of neuron state
- `in_step` in 1: timestep boundary marker, one cycle
- `threshold` in `ACC_WIDTH` signed: firing threshold, sampled on `in_step` cycles
- `in_row` in 1: input spike from west
- `in_col` in `DATA_WIDTH` signed: weight from north
- `out_row` out 1: registered `in_row` to east
- `out_col` out `DATA_WIDTH` signed: registered `in_col` to south
- `out_step` out 1: registered `in_step` to east
- `out_spike` out 1: neuron fired, one-cycle pulse
- `out_potential` out `ACC_WIDTH` signed: current membrane potential
- `out_refrac` out 1: high while in REFRAC state

## Operation
- States: INTEG, REFRAC. Refractory counter `rc` width clog2(`REFRAC_STEPS`+1), minimum 1.
- Forwarding: every non-reset cycle, `out_row`/`out_col`/`out_step` take `in_row`/`in_col`/`in_step`, regardless of state or `in_clear`.
- Priority: `rstn`=0 > `in_clear` > `in_step` > integrate.
- `in_clear`: V=0, state INTEG, `rc`=0, `out_spike`=0.
- INTEG, `in_row`=1, `in_step`=0: V ← sat(V + sext(`in_col`)).
- INTEG, `in_step`=1: Va = sat(V + (`in_row` ? sext(`in_col`) : 0)); Vl = Va − (Va >>> `LEAK_SHIFT`) (Vl = Va if `LEAK_SHIFT`=0). If Vl ≥ `threshold` (signed): `out_spike`=1; V ← 0 (mode 0) or sat(Vl − `threshold`) (mode 1); if `REFRAC_STEPS`>0, state REFRAC, `rc`=`REFRAC_STEPS`. Else V ← Vl, `out_spike`=0.
- REFRAC: `in_row` ignored, V held, no leak. On `in_step`: `rc` decrements; if `rc`=1 before decrement, state INTEG. No firing evaluation on REFRAC steps.
- `out_spike` is 0 on every cycle not described above.
- sat(): clamp to [−2^(`ACC_WIDTH`−1), 2^(`ACC_WIDTH`−1)−1]; compute in `ACC_WIDTH`+1 bits.

## Timing
- Reset values: all outputs 0, V=0, state INTEG, `rc`=0.
- Forwarding latency 1 cycle; `out_step` aligns with the neighbour's integrate of the forwarded `in_row`.
- `out_spike` is high the cycle after the `in_step` cycle that fired; `out_potential` shows the post-reset V in that same cycle.
- Integration result visible on `out_potential` 1 cycle after input.
- Back-to-back `in_step` cycles are legal; each is a full timestep.
- `rstn` or `in_clear` asserted during REFRAC or on an `in_step` cycle: clear wins, no spike.

## Structure
- Package `spiking_pkg`: state enum (INTEG, REFRAC), reset-mode constants (RESET_ZERO=0, RESET_SUB=1), `sat_acc` function parametrised by width.
- One sub-module: `spiking_sat_add` (signed saturating add, `ACC_WIDTH`), used for both integrate and subtract-reset paths.
- The forwarding registers and the neuron core share one always block per concern; no other hierarchy.

## Test plan
- Reset/forward: `rstn`=0 for 2 cycles, then `in_row`=1, `in_col`=5 → all outputs 0 during reset; `out_row`=1, `out_col`=5 one cycle after release.
- Integrate/fire (mode 0, `LEAK_SHIFT`=0, `threshold`=100): 4 cycles `in_col`=30, then `in_step` with `in_row`=0 → V=120, `out_spike` pulse, V=0, `out_refrac`=1.
- Leak: V=64, `LEAK_SHIFT`=4, `threshold`=1000, `in_step` → V=60, no spike; repeat `in_step` → V=57.
- Subtract mode + refractory (`REFRAC_STEPS`=2, `threshold`=100): V=130 at `in_step` → V=30, spike; `in_row`=1 `in_col`=50 ignored for next 2 steps; after 2nd `in_step` state INTEG, next `in_col`=50 gives V=80.
- Saturation: `ACC_WIDTH`=17, `DATA_WIDTH`=16, repeated `in_col`=32767 → V clamps at 65535; repeated −32768 → clamps at −65536.
- Clear priority: `in_clear`=1 on same cycle as a firing `in_step` → no spike, V=0, state INTEG, `out_step`=1 still forwarded.
